// File: rtl/snake_pkg.sv
// Shared encodings and helpers for the snake game controller.
package snake_pkg;

    localparam int COORD_W    = 4;
    localparam int LEN_W      = 6;
    localparam int IDX_W      = 5;
    localparam int DEF_WIDTH  = 16;
    localparam int DEF_HEIGHT = 8;

    typedef enum logic [3:0] {
        DIR_UP    = 4'b0001,
        DIR_RIGHT = 4'b0010,
        DIR_DOWN  = 4'b0100,
        DIR_LEFT  = 4'b1000
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    function automatic dir_t dir_opposite(input dir_t d);
        case (d)
            DIR_UP:    return DIR_DOWN;
            DIR_DOWN:  return DIR_UP;
            DIR_LEFT:  return DIR_RIGHT;
            DIR_RIGHT: return DIR_LEFT;
            default:   return DIR_LEFT;
        endcase
    endfunction

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/snake_if.sv
// Game-facing signal bundle: player/food inputs, status outputs and body read port.
interface snake_if;
    import snake_pkg::*;

    logic                 start;
    logic                 btn_up;
    logic                 btn_down;
    logic                 btn_left;
    logic                 btn_right;
    logic                 food_valid;
    logic [COORD_W-1:0]   food_x;
    logic [COORD_W-1:0]   food_y;
    logic [IDX_W-1:0]     rd_idx;

    logic [COORD_W-1:0]   head_x;
    logic [COORD_W-1:0]   head_y;
    logic [LEN_W-1:0]     len;
    logic [1:0]           state;
    logic                 step;
    logic                 food_eaten;
    logic                 dead;
    logic [COORD_W-1:0]   rd_x;
    logic [COORD_W-1:0]   rd_y;
    logic                 rd_valid;

    modport master (
        output start, btn_up, btn_down, btn_left, btn_right,
        output food_valid, food_x, food_y, rd_idx,
        input  head_x, head_y, len, state, step, food_eaten, dead,
        input  rd_x, rd_y, rd_valid
    );

    modport slave (
        input  start, btn_up, btn_down, btn_left, btn_right,
        input  food_valid, food_x, food_y, rd_idx,
        output head_x, head_y, len, state, step, food_eaten, dead,
        output rd_x, rd_y, rd_valid
    );

endinterface

// File: rtl/snake_body_buf.sv
// Circular body store: segment i lives at slot (ptr - i); advancing writes the new head
// one slot ahead, so the tail falls off implicitly unless len grows.
module snake_body_buf
    import snake_pkg::*;
#(
    parameter int MAX_LEN = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               advance,
    input  logic [COORD_W-1:0] cand_x,
    input  logic [COORD_W-1:0] cand_y,
    input  logic               cand_grow,
    output logic               hit,
    output logic [LEN_W-1:0]   len,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [COORD_W-1:0] rd_x,
    output logic [COORD_W-1:0] rd_y,
    output logic               rd_valid
);

    localparam int PW = $clog2(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    logic [COORD_W-1:0] mem_x_r [MAX_LEN];
    logic [COORD_W-1:0] mem_y_r [MAX_LEN];
    logic [PW-1:0]      ptr_r;
    logic [LEN_W-1:0]   len_r;
    logic [PW-1:0]      ptr_nxt_s;
    logic [COORD_W-1:0] seg_x_s [MAX_LEN];
    logic [COORD_W-1:0] seg_y_s [MAX_LEN];
    logic               hit_s;

    assign ptr_nxt_s = ptr_r + PW'(1'b1);

    for (genvar i = 0; i < MAX_LEN; i++) begin : g_seg
        assign seg_x_s[i] = mem_x_r[ptr_r - PW'(i)];
        assign seg_y_s[i] = mem_y_r[ptr_r - PW'(i)];
    end

    // Segment storage, head pointer and length.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_r <= '0;
            len_r <= 6'd1;
            for (int j = 0; j < MAX_LEN; j++) begin
                mem_x_r[j] <= 4'd0;
                mem_y_r[j] <= 4'd0;
            end
        end else if (clear) begin
            ptr_r <= '0;
            len_r <= 6'd1;
            for (int j = 0; j < MAX_LEN; j++) begin
                mem_x_r[j] <= 4'd0;
                mem_y_r[j] <= 4'd0;
            end
        end else if (advance) begin
            ptr_r              <= ptr_nxt_s;
            mem_x_r[ptr_nxt_s] <= cand_x;
            mem_y_r[ptr_nxt_s] <= cand_y;
            if (cand_grow && (len_r < LEN_MAX)) begin
                len_r <= len_r + 6'd1;
            end
        end
    end

    // Parallel compare; the tail is skipped when it is about to vacate.
    always_comb begin
        hit_s = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((6'(i) < len_r) && !((6'(i) == len_r - 6'd1) && !cand_grow) &&
                (seg_x_s[i] == cand_x) && (seg_y_s[i] == cand_y)) begin
                hit_s = 1'b1;
            end else begin
                hit_s = hit_s;
            end
        end
    end

    // Combinational body read port.
    always_comb begin
        rd_valid = ({1'b0, rd_idx} < len_r);
        if (rd_valid) begin
            rd_x = mem_x_r[ptr_r - rd_idx[PW-1:0]];
            rd_y = mem_y_r[ptr_r - rd_idx[PW-1:0]];
        end else begin
            rd_x = 4'd0;
            rd_y = 4'd0;
        end
    end

    assign hit = hit_s;
    assign len = len_r;

endmodule

// File: rtl/snake_ctrl.sv
// Snake game controller: movement tick, direction arbitration, growth and self-collision.
module snake_ctrl
    import snake_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int HEIGHT   = DEF_HEIGHT,
    parameter int MAX_LEN  = 16,
    parameter int TICK_DIV = 4
) (
    input logic    clk,
    input logic    reset,
    snake_if.slave bus
);

    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0]      TICK_LOAD = TW'(TICK_DIV - 1);
    localparam logic [COORD_W-1:0] X_MAX     = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_MAX     = COORD_W'(HEIGHT - 1);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [TW-1:0]      tick_r;
    logic               step_r;
    dir_t               dir_r;
    dir_t               pend_r;
    logic [COORD_W-1:0] head_x_r;
    logic [COORD_W-1:0] head_y_r;
    logic               eaten_r;
    logic               dead_r;

    logic [3:0]         btn_vec_s;
    logic               req_ok_s;
    logic [COORD_W-1:0] nx_s;
    logic [COORD_W-1:0] ny_s;
    logic               grow_s;
    logic               hit_s;
    logic               advance_s;
    logic               collide_s;
    logic               clear_s;

    assign btn_vec_s = {bus.btn_left, bus.btn_down, bus.btn_right, bus.btn_up};
    assign req_ok_s  = is_onehot4(btn_vec_s) && (btn_vec_s != dir_opposite(dir_r));
    assign grow_s    = bus.food_valid && (nx_s == bus.food_x) && (ny_s == bus.food_y);
    assign advance_s = step_r && (state_r == ST_RUN) && !hit_s;
    assign collide_s = step_r && (state_r == ST_RUN) && hit_s;
    assign clear_s   = (state_r == ST_DEAD) && bus.start;

    // Candidate head from the pending direction, wrapping at the playfield edges.
    always_comb begin
        nx_s = head_x_r;
        ny_s = head_y_r;
        case (pend_r)
            DIR_RIGHT: nx_s = (head_x_r == X_MAX) ? 4'd0 : head_x_r + 4'd1;
            DIR_LEFT:  nx_s = (head_x_r == 4'd0) ? X_MAX : head_x_r - 4'd1;
            DIR_DOWN:  ny_s = (head_y_r == Y_MAX) ? 4'd0 : head_y_r + 4'd1;
            DIR_UP:    ny_s = (head_y_r == 4'd0) ? Y_MAX : head_y_r - 4'd1;
            default: begin
                nx_s = head_x_r;
                ny_s = head_y_r;
            end
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: if (bus.start) state_nxt_s = ST_RUN;  else state_nxt_s = ST_IDLE;
            ST_RUN:  if (collide_s) state_nxt_s = ST_DEAD; else state_nxt_s = ST_RUN;
            ST_DEAD: if (bus.start) state_nxt_s = ST_IDLE; else state_nxt_s = ST_DEAD;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Movement tick: counts only while running, one-cycle step at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_r <= TICK_LOAD;
            step_r <= 1'b0;
        end else if (state_r != ST_RUN) begin
            tick_r <= TICK_LOAD;
            step_r <= 1'b0;
        end else if (tick_r == '0) begin
            tick_r <= TICK_LOAD;
            step_r <= 1'b1;
        end else begin
            tick_r <= tick_r - TW'(1'b1);
            step_r <= 1'b0;
        end
    end

    // Committed and pending direction; a press during the step cycle lands on the next step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dir_r  <= DIR_RIGHT;
            pend_r <= DIR_RIGHT;
        end else if (clear_s) begin
            dir_r  <= DIR_RIGHT;
            pend_r <= DIR_RIGHT;
        end else begin
            if (advance_s) begin
                dir_r <= pend_r;
            end
            if (req_ok_s) begin
                pend_r <= dir_t'(btn_vec_s);
            end
        end
    end

    // Head position and status flags, updated the cycle after step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_x_r <= 4'd0;
            head_y_r <= 4'd0;
            eaten_r  <= 1'b0;
            dead_r   <= 1'b0;
        end else if (clear_s) begin
            head_x_r <= 4'd0;
            head_y_r <= 4'd0;
            eaten_r  <= 1'b0;
            dead_r   <= 1'b0;
        end else begin
            eaten_r <= advance_s && grow_s;
            if (advance_s) begin
                head_x_r <= nx_s;
                head_y_r <= ny_s;
            end
            if (collide_s) begin
                dead_r <= 1'b1;
            end
        end
    end

    snake_body_buf #(
        .MAX_LEN (MAX_LEN)
    ) u_body (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear_s),
        .advance   (advance_s),
        .cand_x    (nx_s),
        .cand_y    (ny_s),
        .cand_grow (grow_s),
        .hit       (hit_s),
        .len       (bus.len),
        .rd_idx    (bus.rd_idx),
        .rd_x      (bus.rd_x),
        .rd_y      (bus.rd_y),
        .rd_valid  (bus.rd_valid)
    );

    assign bus.head_x     = head_x_r;
    assign bus.head_y     = head_y_r;
    assign bus.state      = state_r;
    assign bus.step       = step_r;
    assign bus.food_eaten = eaten_r;
    assign bus.dead       = dead_r;

endmodule

// File: doc/snake_ctrl.md
SNAKE_CTRL -- requirements
Module: snake_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, playfield columns (x range 0..WIDTH-1, WIDTH <= 16).
REQ-002 SHALL have parameter HEIGHT, default 8, playfield rows (y range 0..HEIGHT-1, HEIGHT <= 16).
REQ-003 SHALL have parameter MAX_LEN, default 16, body buffer depth in segments (power of two, 2..32).
REQ-004 SHALL have parameter TICK_DIV, default 4, clk cycles per movement step (>= 2).
REQ-005 SHALL have ports: clk input 1, system clock; reset input 1, asynchronous active-low reset.
REQ-006 SHALL have ports: start input 1, begin/restart game pulse; btn_up, btn_down, btn_left, btn_right input 1 each, level direction requests.
REQ-007 SHALL have ports: food_valid input 1, food present; food_x input 4, food_y input 4, food position.
REQ-008 SHALL have ports: head_x output 4, head_y output 4, head position; len output 6, current length; state output 2, FSM state; step output 1, movement pulse; food_eaten output 1, growth pulse; dead output 1, game-over flag.
REQ-009 SHALL have ports: rd_idx input 5, body read index (0 = head); rd_x output 4, rd_y output 4, rd_valid output 1, combinational body read.

Function
REQ-010 SHALL implement FSM IDLE(0) -> RUN(1) on start; RUN -> DEAD(2) on self-collision; DEAD -> IDLE on start; start ignored in RUN.
REQ-011 On any IDLE entry (reset or start from DEAD): len=1, segment 0=(0,0), direction RIGHT, pending direction RIGHT, tick counter=TICK_DIV-1.
REQ-012 Tick counter decrements every clk in RUN only; at 0 it SHALL assert step for exactly one cycle and reload TICK_DIV-1; counter held at TICK_DIV-1 outside RUN.
REQ-013 Direction request accepted only when exactly one btn_* is high; zero or multiple buttons leave pending direction unchanged.
REQ-014 Request opposite to the current (committed) direction SHALL be rejected; pending direction is registered, buttons in the step cycle affect the following step.
REQ-015 On step, committed direction <= pending direction and new head computed from it: RIGHT x+1, LEFT x-1, DOWN y+1, UP y-1.
REQ-016 Wrap-around: x=WIDTH-1 moving RIGHT -> 0; x=0 moving LEFT -> WIDTH-1; same for y with HEIGHT.
REQ-017 Head, body, len, food_eaten, dead SHALL update in the cycle after step (one-cycle latency).
REQ-018 Growth: food_valid high and new head == (food_x, food_y) in step cycle -> food_eaten pulses one cycle, len+1 saturating at MAX_LEN (pulse still issued at saturation).
REQ-019 Without growth, tail segment vacates; body shifts so index i holds former index i-1.
REQ-020 Collision: new head equal to any segment index 0..len-1, excluding index len-1 when not growing; on collision head/body/len SHALL NOT update, state -> DEAD, dead=1.
REQ-021 rd_x/rd_y SHALL return segment rd_idx combinationally; rd_valid=1 iff rd_idx < len; rd_x/rd_y=0 when invalid.
REQ-022 Simultaneous step and collision with food: collision wins, food_eaten stays 0.

Reset
REQ-023 reset low SHALL asynchronously force state=IDLE, head=(0,0), len=1, step=0, food_eaten=0, dead=0, direction and pending RIGHT, counter TICK_DIV-1, all body entries (0,0).
REQ-024 Reset asserted mid-RUN SHALL abort the game with no further step pulses until start after release.

Structure
REQ-025 Package snake_pkg SHALL hold direction encoding (one-hot UP/RIGHT/DOWN/LEFT), state encoding, default WIDTH/HEIGHT constants.
REQ-026 Body storage SHALL be sub-module snake_body_buf: circular buffer with head pointer, shift/grow control, parallel collision compare, read port.
REQ-027 No latches, no clocks other than clk, single always-block reset style for all state.

Verification
REQ-028 Reset then start, no buttons, TICK_DIV=4: step every 4 cycles; head (1,0),(2,0)...; after 16 steps head=(0,0) (wrap).
REQ-029 Head (0,0) RIGHT, press btn_left only -> rejected, next head (1,0); press btn_up -> next head (1,HEIGHT-1).
REQ-030 food_valid=1, food=(2,0), start at (0,0) RIGHT: second step gives food_eaten pulse, len=2, rd_idx 1 = (1,0).
REQ-031 Grow to len 5, steer DOWN, LEFT, UP: head hits own segment -> state=DEAD, dead=1, head unchanged, no further steps; start -> IDLE, len=1, head=(0,0).
REQ-032 btn_up and btn_right high together -> pending unchanged; reset pulse mid-RUN -> all outputs at reset values, step stays 0 until start.
